// File: rtl/dma_desc_prefetcher.sv
// Generic single-clock FIFO holding descriptors between the fetch path and the engine.
// Latency: a push is visible on rd_vld/rd_dat the next cycle; a pop presents the next entry the next cycle.
// Backpressure: writes are dropped when full (the owner never pushes when full); reads stall on rd_rdy.
module dma_desc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign rd_vld = (count != '0);
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && (count != CW'(DEPTH));
    assign rd_dat = mem[rd_ptr];

    // Storage and pointers; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (do_wr && !do_rd) begin
            count <= count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count <= count - CW'(1);
        end
    end
endmodule

// Descriptor prefetcher: walks the DDR ring ahead of the DMA engine and queues descriptors locally.
// Latency: tail seen in IDLE -> arvalid next cycle; rlast beat -> o_desc_valid next cycle; done -> head next cycle.
// Backpressure: fetching pauses while queued + executing descriptors equal FIFO_DEPTH; engine stalls via i_desc_ready.
module dma_desc_prefetcher #(
    parameter int ADDR_WIDTH = 32,
    parameter int DESC_WORDS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [31:0]           i_ring_base,
    input  logic [31:0]           i_ring_size,
    input  logic [PTR_WIDTH-1:0]  i_sw_tail_ptr,
    output logic [PTR_WIDTH-1:0]  o_hw_head_ptr,
    output logic                  o_busy,
    output logic                  o_err,
    output logic                  o_desc_valid,
    input  logic                  i_desc_ready,
    output logic [31:0]           o_dma_addr,
    output logic [31:0]           o_dma_len,
    output logic                  o_dma_algo,
    input  logic                  i_dma_done,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_SHIFT = $clog2(DESC_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_ERR} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PTR_WIDTH-1:0]  ring_len;
    logic [PTR_WIDTH-1:0]  ring_last;
    logic [PTR_WIDTH-1:0]  fetch_ptr;
    logic [PTR_WIDTH-1:0]  head_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      exec_cnt;
    logic [CNT_W-1:0]      slots;
    logic [31:0]           word0;
    logic [31:0]           word1;
    logic [31:0]           push_w1;
    logic [2:0]            beat_cnt;
    logic [63:0]           fifo_rd_dat;
    logic [ADDR_WIDTH-1:0] araddr_nxt;
    logic                  can_fetch;
    logic                  start_fetch;
    logic                  r_beat;
    logic                  bad_beat;
    logic                  burst_bad;
    logic                  push;
    logic                  pop;
    logic                  done_ok;
    logic                  unused_bits;

    assign ring_len  = i_ring_size[PTR_WIDTH-1:0];
    assign ring_last = ring_len - PTR_WIDTH'(1);
    assign slots     = fifo_cnt + exec_cnt;

    assign can_fetch   = i_enable && (ring_len != '0) && (fetch_ptr != i_sw_tail_ptr)
                         && (slots < CNT_W'(FIFO_DEPTH)) && !o_err;
    assign start_fetch = (state == S_IDLE) && can_fetch;
    assign araddr_nxt  = ADDR_WIDTH'(i_ring_base) + (ADDR_WIDTH'(fetch_ptr) << ADDR_SHIFT);

    // o_err can only have been set during the current burst, since IDLE refuses to fetch once it is up
    assign r_beat    = (state == S_R) && m_axi_rvalid;
    assign bad_beat  = r_beat && (m_axi_rresp != 2'b00);
    assign burst_bad = o_err || bad_beat;
    assign push      = r_beat && m_axi_rlast && !burst_bad;
    assign pop       = o_desc_valid && i_desc_ready;
    assign done_ok   = i_dma_done && (exec_cnt != '0);

    // With two-word descriptors word1 arrives on the rlast beat itself
    assign push_w1 = (beat_cnt == 3'd1) ? m_axi_rdata : word1;

    assign m_axi_arlen   = 8'(DESC_WORDS - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;

    assign o_hw_head_ptr = head_ptr;
    assign o_busy        = (state != S_IDLE) || (fifo_cnt != '0) || (exec_cnt != '0);
    assign o_dma_addr    = fifo_rd_dat[63:32];
    assign o_dma_len     = {8'b0, fifo_rd_dat[23:0]};
    assign o_dma_algo    = fifo_rd_dat[31];

    assign unused_bits = ^{i_ring_size, i_ring_base, fifo_rd_dat[30:24]};

    dma_desc_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat ({word0, push_w1}),
        .rd_vld (o_desc_valid),
        .rd_rdy (i_desc_ready),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_cnt)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one burst at a time; an errored burst drains to rlast then parks in ERR
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (can_fetch) state_nxt = S_AR;
            S_AR:    if (m_axi_arready) state_nxt = S_R;
            S_R:     if (r_beat && m_axi_rlast) state_nxt = burst_bad ? S_ERR : S_IDLE;
            default: state_nxt = S_ERR;
        endcase
    end

    // FSM outputs: AXI handshake strobes follow the state directly
    always_comb begin
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            S_AR:    m_axi_arvalid = 1'b1;
            S_R:     m_axi_rready  = 1'b1;
            default: ;
        endcase
    end

    // Burst address, captured as the FSM leaves IDLE so it is stable for the whole AR phase
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_araddr <= '0;
        end else if (start_fetch) begin
            m_axi_araddr <= araddr_nxt;
        end
    end

    // Beat capture: keep words 0 and 1, ignore the rest of the burst
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            word0    <= '0;
            word1    <= '0;
        end else if (state == S_AR) begin
            beat_cnt <= '0;
        end else if (r_beat) begin
            if (beat_cnt == 3'd0) word0 <= m_axi_rdata;
            if (beat_cnt == 3'd1) word1 <= m_axi_rdata;
            if (beat_cnt != 3'd7) beat_cnt <= beat_cnt + 3'd1;
        end
    end

    // Ring pointers: fetch advances on a clean push, head on a counted completion
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_ptr <= '0;
            head_ptr  <= '0;
        end else begin
            if (push) fetch_ptr <= (fetch_ptr == ring_last) ? '0 : fetch_ptr + PTR_WIDTH'(1);
            if (done_ok) head_ptr <= (head_ptr == ring_last) ? '0 : head_ptr + PTR_WIDTH'(1);
        end
    end

    // In-flight count at the engine; pop and done together cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt <= '0;
        end else if (pop && !done_ok) begin
            exec_cnt <= exec_cnt + CNT_W'(1);
        end else if (!pop && done_ok) begin
            exec_cnt <= exec_cnt - CNT_W'(1);
        end
    end

    // Sticky read-error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (bad_beat) begin
            o_err <= 1'b1;
        end
    end
endmodule
